// File: rtl/conv33_calc.sv
// Five-stage pipelined 3x3 signed convolution MAC: nine 8x8 products, adder tree, bias add.
// Intermediate stage registers are brought out as debug ports.
module conv33_calc #(
   parameter int MUL_WIDTH = 16,
   parameter int OUT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 conv33_en,
   input  logic [7:0]           data_0_0,
   input  logic [7:0]           data_0_1,
   input  logic [7:0]           data_0_2,
   input  logic [7:0]           data_1_0,
   input  logic [7:0]           data_1_1,
   input  logic [7:0]           data_1_2,
   input  logic [7:0]           data_2_0,
   input  logic [7:0]           data_2_1,
   input  logic [7:0]           data_2_2,
   input  logic [7:0]           weight_0,
   input  logic [7:0]           weight_1,
   input  logic [7:0]           weight_2,
   input  logic [7:0]           weight_3,
   input  logic [7:0]           weight_4,
   input  logic [7:0]           weight_5,
   input  logic [7:0]           weight_6,
   input  logic [7:0]           weight_7,
   input  logic [7:0]           weight_8,
   input  logic [OUT_WIDTH-1:0] bias,
   output logic [OUT_WIDTH-1:0] result,
   output logic                 valid,
   output logic [MUL_WIDTH-1:0] mul_0,
   output logic [MUL_WIDTH-1:0] mul_1,
   output logic [MUL_WIDTH-1:0] mul_2,
   output logic [MUL_WIDTH-1:0] mul_3,
   output logic [MUL_WIDTH-1:0] mul_4,
   output logic [MUL_WIDTH-1:0] mul_5,
   output logic [MUL_WIDTH-1:0] mul_6,
   output logic [MUL_WIDTH-1:0] mul_7,
   output logic [MUL_WIDTH-1:0] mul_8,
   output logic [MUL_WIDTH:0]   sum0,
   output logic [MUL_WIDTH:0]   sum1,
   output logic [MUL_WIDTH:0]   sum2,
   output logic [MUL_WIDTH:0]   sum3,
   output logic [MUL_WIDTH+1:0] sum4,
   output logic [MUL_WIDTH+1:0] sum5,
   output logic [OUT_WIDTH-1:0] convsum
);
   localparam int S2W = MUL_WIDTH + 1;
   localparam int S3W = MUL_WIDTH + 2;

   logic [7:0] px [9];
   logic [7:0] wt [9];
   assign px = '{data_0_0, data_0_1, data_0_2, data_1_0, data_1_1, data_1_2,
                 data_2_0, data_2_1, data_2_2};
   assign wt = '{weight_0, weight_1, weight_2, weight_3, weight_4, weight_5,
                 weight_6, weight_7, weight_8};

   logic [5:1]                  vld_q;
   logic signed [MUL_WIDTH-1:0] mul_d [9];
   logic signed [MUL_WIDTH-1:0] mul_q [9];
   logic signed [S2W-1:0]       sum_d [4];
   logic signed [S2W-1:0]       sum_q [4];
   logic signed [S3W-1:0]       sum4_q, sum5_q;
   logic signed [MUL_WIDTH-1:0] mul8_q2, mul8_q3;
   logic signed [OUT_WIDTH-1:0] bias_q1, bias_q2, bias_q3, bias_q4;
   logic signed [OUT_WIDTH-1:0] convsum_q, convsum_d, result_q;

   // Operands are widened first so the truncated product is the exact 16-bit result.
   for (genvar k = 0; k < 9; k++) begin : g_mul
      assign mul_d[k] = MUL_WIDTH'($signed(px[k])) * MUL_WIDTH'($signed(wt[k]));
   end

   for (genvar i = 0; i < 4; i++) begin : g_sum
      assign sum_d[i] = S2W'(mul_q[2*i]) + S2W'(mul_q[2*i+1]);
   end

   assign convsum_d = OUT_WIDTH'(sum4_q) + OUT_WIDTH'(sum5_q) + OUT_WIDTH'(mul8_q3);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q     <= '0;
         for (int k = 0; k < 9; k++) mul_q[k] <= '0;
         for (int i = 0; i < 4; i++) sum_q[i] <= '0;
         sum4_q    <= '0;
         sum5_q    <= '0;
         mul8_q2   <= '0;
         mul8_q3   <= '0;
         bias_q1   <= '0;
         bias_q2   <= '0;
         bias_q3   <= '0;
         bias_q4   <= '0;
         convsum_q <= '0;
         result_q  <= '0;
      end else begin
         vld_q <= {vld_q[4:1], conv33_en};
         if (conv33_en) begin
            for (int k = 0; k < 9; k++) mul_q[k] <= mul_d[k];
            bias_q1 <= $signed(bias);
         end
         if (vld_q[1]) begin
            for (int i = 0; i < 4; i++) sum_q[i] <= sum_d[i];
            mul8_q2 <= mul_q[8];
            bias_q2 <= bias_q1;
         end
         if (vld_q[2]) begin
            sum4_q  <= S3W'(sum_q[0]) + S3W'(sum_q[1]);
            sum5_q  <= S3W'(sum_q[2]) + S3W'(sum_q[3]);
            mul8_q3 <= mul8_q2;
            bias_q3 <= bias_q2;
         end
         if (vld_q[3]) begin
            convsum_q <= convsum_d;
            bias_q4   <= bias_q3;
         end
         // Only the bias add can wrap; the nine-product sum always fits.
         if (vld_q[4]) result_q <= convsum_q + bias_q4;
      end
   end

   assign valid   = vld_q[5];
   assign result  = result_q;
   assign convsum = convsum_q;
   assign mul_0 = mul_q[0];
   assign mul_1 = mul_q[1];
   assign mul_2 = mul_q[2];
   assign mul_3 = mul_q[3];
   assign mul_4 = mul_q[4];
   assign mul_5 = mul_q[5];
   assign mul_6 = mul_q[6];
   assign mul_7 = mul_q[7];
   assign mul_8 = mul_q[8];
   assign sum0  = sum_q[0];
   assign sum1  = sum_q[1];
   assign sum2  = sum_q[2];
   assign sum3  = sum_q[3];
   assign sum4  = sum4_q;
   assign sum5  = sum5_q;
endmodule

// File: tb/tb_conv33_calc.sv
// Directed bench for conv33_calc: stage-by-stage debug values, extremes, streaming, async reset.
module tb_conv33_calc;
   logic               clk = 1'b0;
   logic               rst;
   logic               en;
   logic [7:0]         d [9];
   logic [7:0]         w [9];
   logic [31:0]        bias;
   logic signed [31:0] result, convsum;
   logic               valid;
   logic signed [15:0] mul [9];
   logic signed [16:0] sm [4];
   logic signed [17:0] sum4, sum5;
   int checks = 0;
   int errs   = 0;

   always #5 clk = ~clk;

   conv33_calc dut (
      .clk(clk), .rst(rst), .conv33_en(en),
      .data_0_0(d[0]), .data_0_1(d[1]), .data_0_2(d[2]),
      .data_1_0(d[3]), .data_1_1(d[4]), .data_1_2(d[5]),
      .data_2_0(d[6]), .data_2_1(d[7]), .data_2_2(d[8]),
      .weight_0(w[0]), .weight_1(w[1]), .weight_2(w[2]),
      .weight_3(w[3]), .weight_4(w[4]), .weight_5(w[5]),
      .weight_6(w[6]), .weight_7(w[7]), .weight_8(w[8]),
      .bias(bias), .result(result), .valid(valid),
      .mul_0(mul[0]), .mul_1(mul[1]), .mul_2(mul[2]), .mul_3(mul[3]), .mul_4(mul[4]),
      .mul_5(mul[5]), .mul_6(mul[6]), .mul_7(mul[7]), .mul_8(mul[8]),
      .sum0(sm[0]), .sum1(sm[1]), .sum2(sm[2]), .sum3(sm[3]),
      .sum4(sum4), .sum5(sum5), .convsum(convsum)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [7:0] dv, input logic [7:0] wv, input bit ramp);
      for (int k = 0; k < 9; k++) begin
         d[k] = ramp ? 8'(k + 1) : dv;
         w[k] = wv;
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; bias = '0;
      load(8'd0, 8'd0, 1'b0);
      #1 rst = 1'b0;
      step();
      chk("rst_result", result, 0);
      chk("rst_valid", valid, 0);
      chk("rst_convsum", convsum, 0);
      chk("rst_mul0", mul[0], 0);
      chk("rst_sum4", sum4, 0);
      rst = 1'b1;

      // Sum of 1..9 with unit weights; inputs scrambled right after sampling.
      load(8'd0, 8'd1, 1'b1); bias = 32'd1; en = 1'b1;
      step();
      for (int k = 0; k < 9; k++) chk($sformatf("t1_mul%0d", k), mul[k], k + 1);
      chk("t1_valid_s1", valid, 0);
      en = 1'b0; load(8'd99, 8'd77, 1'b0); bias = 32'd1000;
      step();
      chk("t1_sum0", sm[0], 3);
      chk("t1_sum1", sm[1], 7);
      chk("t1_sum2", sm[2], 11);
      chk("t1_sum3", sm[3], 15);
      chk("t1_valid_s2", valid, 0);
      step();
      chk("t1_sum4", sum4, 10);
      chk("t1_sum5", sum5, 26);
      chk("t1_valid_s3", valid, 0);
      step();
      chk("t1_convsum", convsum, 45);
      chk("t1_valid_s4", valid, 0);
      step();
      chk("t1_result", result, 46);
      chk("t1_valid", valid, 1);
      step();
      chk("t1_valid_drop", valid, 0);
      chk("t1_result_hold", result, 46);

      // Extreme positive: (-128)*(-128) everywhere, bias -1.
      load(8'h80, 8'h80, 1'b0); bias = 32'hFFFF_FFFF; en = 1'b1;
      step();
      en = 1'b0;
      chk("t2_mul4", mul[4], 16384);
      step(); step(); step();
      chk("t2_convsum", convsum, 147456);
      step();
      chk("t2_result", result, 147455);
      chk("t2_valid", valid, 1);

      // Extreme negative: (-128)*127 everywhere, bias 0.
      load(8'h80, 8'd127, 1'b0); bias = 32'd0; en = 1'b1;
      step();
      en = 1'b0;
      chk("t3_mul8", mul[8], -16256);
      step(); step(); step();
      chk("t3_convsum", convsum, -146304);
      step();
      chk("t3_result", result, -146304);

      // Streaming three windows: +45, 0, -45.
      bias = 32'd0; en = 1'b1;
      load(8'd0, 8'd1, 1'b1);
      step();
      load(8'd0, 8'd0, 1'b0);
      step();
      load(8'd0, 8'hFF, 1'b1);
      step();
      en = 1'b0; load(8'd5, 8'd5, 1'b0);
      step();
      chk("st_valid_pre", valid, 0);
      step();
      chk("st_valid0", valid, 1);
      chk("st_result0", result, 45);
      step();
      chk("st_valid1", valid, 1);
      chk("st_result1", result, 0);
      step();
      chk("st_valid2", valid, 1);
      chk("st_result2", result, -45);
      step();
      chk("st_valid_end", valid, 0);
      chk("st_result_hold", result, -45);

      // Async reset mid-pipeline, plus an enable presented while in reset.
      load(8'd0, 8'd1, 1'b1); bias = 32'd7; en = 1'b1;
      step();
      en = 1'b0;
      step(); step();
      #2 rst = 1'b0;
      #1;
      chk("ar_result", result, 0);
      chk("ar_convsum", convsum, 0);
      chk("ar_mul0", mul[0], 0);
      chk("ar_sum0", sm[0], 0);
      chk("ar_sum5", sum5, 0);
      chk("ar_valid", valid, 0);
      en = 1'b1;
      step();
      en = 1'b0;
      #2 rst = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step();
         chk($sformatf("ar_no_valid%0d", i), valid, 0);
      end
      chk("ar_result_after", result, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errs);
      $finish;
   end
endmodule
